// File: rtl/key_entry_pkg.sv
// Shared key codes, ASCII bases and FSM state type for the keyboard text-entry path.
package key_entry_pkg;

    localparam logic [4:0] CODE_LAST_LETTER = 5'd25;
    localparam logic [4:0] CODE_BKSP        = 5'd26;
    localparam logic [4:0] CODE_CAPS        = 5'd27;
    localparam logic [4:0] CODE_ENTER       = 5'd28;
    localparam logic [4:0] CODE_SPACE       = 5'd29;

    localparam logic [6:0] ASCII_LOWER_A = 7'h61;
    localparam logic [6:0] ASCII_UPPER_A = 7'h41;
    localparam logic [6:0] ASCII_SPACE   = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    // Caps lock and enter toggle/commit once per physical press; everything else may repeat.
    function automatic logic is_repeatable(input logic [4:0] code);
        return (code <= CODE_BKSP) || (code == CODE_SPACE);
    endfunction

endpackage

// File: rtl/key_char_map.sv
// Combinational key-code to ASCII translation; flags codes that insert a character.
module key_char_map
    import key_entry_pkg::*;
(
    input  logic [4:0] code_i,
    input  logic       capital_i,
    output logic [6:0] ascii_o,
    output logic       is_insert_o
);

    always_comb begin
        ascii_o     = '0;
        is_insert_o = 1'b0;
        if (code_i <= CODE_LAST_LETTER) begin
            ascii_o     = (capital_i ? ASCII_UPPER_A : ASCII_LOWER_A) + {2'b00, code_i};
            is_insert_o = 1'b1;
        end else if (code_i == CODE_SPACE) begin
            ascii_o     = ASCII_SPACE;
            is_insert_o = 1'b1;
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Keyboard text-entry controller: press FSM, caps lock, DEPTH-character line buffer, commit.
// Define KEY_ENTRY_REPEAT_EN to compile in hold-to-repeat for letters, space and backspace.
module key_entry_ctrl
    import key_entry_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [4:0]                   digit,
    input  logic [511:0]                 key_down,
    output logic                         capital,
    output logic [7*DEPTH-1:0]           char_buf,
    output logic [$clog2(DEPTH+1)-1:0]   char_cnt,
    output logic                         commit_valid,
    output logic [7*DEPTH-1:0]           commit_data,
    output logic [$clog2(DEPTH+1)-1:0]   commit_cnt,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || DEPTH > 8 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("key_entry_ctrl: DEPTH must be 2..8 and repeat timings at least 2");
    end

    state_e             state_q, state_d;
    logic [4:0]         code_q, code_d;
    logic               capital_q, capital_d;
    logic [6:0]         chars_q [DEPTH];
    logic [6:0]         chars_d [DEPTH];
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               commit_valid_q, commit_valid_d;
    logic [7*DEPTH-1:0] commit_data_q, commit_data_d;
    logic [CW-1:0]      commit_cnt_q, commit_cnt_d;
    logic               overflow_q, overflow_d;

    logic               any_key;
    logic [6:0]         ascii;
    logic               is_insert;

`ifdef KEY_ENTRY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          repeat_q, repeat_d;
`endif

    assign any_key = |key_down;

    key_char_map u_char_map (
        .code_i      (code_q),
        .capital_i   (capital_q),
        .ascii_o     (ascii),
        .is_insert_o (is_insert)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            char_buf[7*i +: 7] = chars_q[i];
        end
    end

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        capital_d      = capital_q;
        chars_d        = chars_q;
        cnt_d          = cnt_q;
        commit_valid_d = 1'b0;
        commit_data_d  = commit_data_q;
        commit_cnt_d   = commit_cnt_q;
        overflow_d     = 1'b0;
`ifdef KEY_ENTRY_REPEAT_EN
        rep_cnt_d      = rep_cnt_q;
        repeat_d       = repeat_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_key) begin
                    state_d = S_PRESS;
                    code_d  = digit;
`ifdef KEY_ENTRY_REPEAT_EN
                    repeat_d = 1'b0;
`endif
                end
            end

            S_PRESS: begin
                state_d = S_HOLD;
`ifdef KEY_ENTRY_REPEAT_EN
                // Intervals are counted press-to-press, so the PRESS cycle itself is one of them.
                rep_cnt_d = repeat_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
`endif
                if (is_insert) begin
                    if (cnt_q == CW'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (i == int'(cnt_q)) chars_d[i] = ascii;
                        end
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    case (code_q)
                        CODE_BKSP: begin
                            if (cnt_q != '0) begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    if (i == int'(cnt_q) - 1) chars_d[i] = '0;
                                end
                                cnt_d = cnt_q - CW'(1);
                            end
                        end
                        CODE_CAPS: capital_d = ~capital_q;
                        CODE_ENTER: begin
                            commit_valid_d = 1'b1;
                            commit_data_d  = char_buf;
                            commit_cnt_d   = cnt_q;
                            for (int i = 0; i < DEPTH; i++) chars_d[i] = '0;
                            cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end

            S_HOLD: begin
                if (!any_key) begin
                    state_d = S_IDLE;
                end
`ifdef KEY_ENTRY_REPEAT_EN
                else begin
                    if (rep_cnt_q == RW'(1) && is_repeatable(code_q)) begin
                        state_d  = S_PRESS;
                        repeat_d = 1'b1;
                    end
                    if (rep_cnt_q != '0) rep_cnt_d = rep_cnt_q - RW'(1);
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            code_q         <= '0;
            capital_q      <= 1'b0;
            // NOTE: the line buffer is reset because an aborted line must read back as all zeros.
            chars_q        <= '{default: '0};
            cnt_q          <= '0;
            commit_valid_q <= 1'b0;
            commit_data_q  <= '0;
            commit_cnt_q   <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            capital_q      <= capital_d;
            chars_q        <= chars_d;
            cnt_q          <= cnt_d;
            commit_valid_q <= commit_valid_d;
            commit_data_q  <= commit_data_d;
            commit_cnt_q   <= commit_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

`ifdef KEY_ENTRY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end
`endif

    assign capital      = capital_q;
    assign char_cnt     = cnt_q;
    assign commit_valid = commit_valid_q;
    assign commit_data  = commit_data_q;
    assign commit_cnt   = commit_cnt_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed table, hand-written corner cases, random presses.
module tb_key_entry_ctrl;

    localparam int DEPTH    = 4;
    localparam int CW       = 3;
    localparam int DW       = 7 * DEPTH;
    localparam int R_DELAY  = 10;
    localparam int R_PERIOD = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4:0]     digit = '0;
    logic [511:0]   key_down = '0;
    logic           capital;
    logic [DW-1:0]  char_buf;
    logic [CW-1:0]  char_cnt;
    logic           commit_valid;
    logic [DW-1:0]  commit_data;
    logic [CW-1:0]  commit_cnt;
    logic           overflow;

    always #5 clk = ~clk;

    key_entry_ctrl #(
        .DEPTH         (DEPTH),
        .REPEAT_DELAY  (R_DELAY),
        .REPEAT_PERIOD (R_PERIOD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit        (digit),
        .key_down     (key_down),
        .capital      (capital),
        .char_buf     (char_buf),
        .char_cnt     (char_cnt),
        .commit_valid (commit_valid),
        .commit_data  (commit_data),
        .commit_cnt   (commit_cnt),
        .overflow     (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts commit/overflow cycles and keeps the latest commit snapshot.
    int            mon_commits, mon_ovf;
    logic [DW-1:0] mon_cdata;
    logic [CW-1:0] mon_ccnt;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_commits = 0;
            mon_ovf     = 0;
            mon_cdata   = '0;
            mon_ccnt    = '0;
        end else begin
            if (commit_valid) begin
                mon_commits++;
                mon_cdata = commit_data;
                mon_ccnt  = commit_cnt;
            end
            if (overflow) mon_ovf++;
        end
    end

    // Reference model: the line is a queue of characters.
    byte unsigned  m_line[$];
    bit            m_cap;
    int            m_commits, m_ovf, m_ccnt;
    logic [DW-1:0] m_cdata;

    function automatic logic [DW-1:0] pack_line();
        logic [DW-1:0] r = '0;
        foreach (m_line[i]) r[7*i +: 7] = m_line[i][6:0];
        return r;
    endfunction

    function automatic void model_insert(input byte unsigned ch);
        if (m_line.size() == DEPTH) m_ovf++;
        else m_line.push_back(ch);
    endfunction

    function automatic void model_key(input int code);
        if (code < 26)       model_insert(byte'((m_cap ? 65 : 97) + code)); // 'A' / 'a'
        else if (code == 26) begin if (m_line.size() > 0) void'(m_line.pop_back()); end
        else if (code == 27) m_cap = !m_cap;
        else if (code == 28) begin
            m_commits++;
            m_cdata = pack_line();
            m_ccnt  = m_line.size();
            m_line.delete();
        end
        else if (code == 29) model_insert(8'h20);
    endfunction

    // Extra events produced by holding a key for 'hold' sampled edges.
    function automatic int model_repeats(input int code, input int hold);
        int n = 0;
`ifdef KEY_ENTRY_REPEAT_EN
        if (code <= 26 || code == 29)
            for (int t = R_DELAY; t <= hold - 1; t += R_PERIOD) n++;
`endif
        return n;
    endfunction

    function automatic logic [DW-1:0] pk(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c, input logic [6:0] d);
        return {d, c, b, a};
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        key_down = '0;
        digit    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_line.delete();
        m_cap = 0; m_commits = 0; m_ovf = 0; m_ccnt = 0; m_cdata = '0;
        @(negedge clk);
    endtask

    task automatic key_on(input logic [4:0] code);
        digit    = code;
        key_down = '0;
        key_down[$urandom_range(511, 0)] = 1'b1;
    endtask

    // Press for 'hold' sampled edges, scrambling digit while held, then settle back to idle.
    task automatic press(input logic [4:0] code, input int hold);
        key_on(code);
        repeat (hold) begin
            @(negedge clk);
            digit = 5'($urandom);
        end
        key_down = '0;
        repeat (2) @(negedge clk);
        model_key(int'(code));
        for (int r = 0; r < model_repeats(int'(code), hold); r++) model_key(int'(code));
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cnt"},     64'(char_cnt),    64'(m_line.size()));
        check({tag, ".buf"},     64'(char_buf),    64'(pack_line()));
        check({tag, ".cap"},     64'(capital),     64'(m_cap));
        check({tag, ".commits"}, 64'(mon_commits), 64'(m_commits));
        check({tag, ".ovf"},     64'(mon_ovf),     64'(m_ovf));
        check({tag, ".cdata"},   64'(mon_cdata),   64'(m_cdata));
        check({tag, ".ccnt"},    64'(mon_ccnt),    64'(m_ccnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctl"},   64'({capital, char_cnt, commit_valid, commit_cnt, overflow}), 64'(0));
        check({tag, ".buf"},   64'(char_buf),    64'(0));
        check({tag, ".cdata"}, 64'(commit_data), 64'(0));
    endtask

    typedef struct {
        logic [4:0]    code;
        int            cnt;
        bit            cap;
        logic [DW-1:0] buf_v;
        int            ovf;
        int            commits;
        logic [DW-1:0] cdata;
        int            ccnt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{5'd0,  1, 1'b1 & 1'b0, pk(7'h61, 0, 0, 0), 0, 0, '0, 0};
        vecs[1]  = '{5'd27, 1, 1'b1, pk(7'h61, 0, 0, 0), 0, 0, '0, 0};
        vecs[2]  = '{5'd7,  2, 1'b1, pk(7'h61, 7'h48, 0, 0), 0, 0, '0, 0};
        vecs[3]  = '{5'd27, 2, 1'b0, pk(7'h61, 7'h48, 0, 0), 0, 0, '0, 0};
        vecs[4]  = '{5'd29, 3, 1'b0, pk(7'h61, 7'h48, 7'h20, 0), 0, 0, '0, 0};
        vecs[5]  = '{5'd30, 3, 1'b0, pk(7'h61, 7'h48, 7'h20, 0), 0, 0, '0, 0};
        vecs[6]  = '{5'd1,  4, 1'b0, pk(7'h61, 7'h48, 7'h20, 7'h62), 0, 0, '0, 0};
        vecs[7]  = '{5'd3,  4, 1'b0, pk(7'h61, 7'h48, 7'h20, 7'h62), 1, 0, '0, 0};
        vecs[8]  = '{5'd26, 3, 1'b0, pk(7'h61, 7'h48, 7'h20, 0), 1, 0, '0, 0};
        vecs[9]  = '{5'd26, 2, 1'b0, pk(7'h61, 7'h48, 0, 0), 1, 0, '0, 0};
        vecs[10] = '{5'd31, 2, 1'b0, pk(7'h61, 7'h48, 0, 0), 1, 0, '0, 0};
        vecs[11] = '{5'd28, 0, 1'b0, '0, 1, 1, pk(7'h61, 7'h48, 0, 0), 2};
        vecs[12] = '{5'd28, 0, 1'b0, '0, 1, 2, '0, 0};
        vecs[13] = '{5'd26, 0, 1'b0, '0, 1, 2, '0, 0};

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Two-edge latency of the first insert
        key_on(5'd0);
        @(negedge clk);
        check("lat.e0_cnt", 64'(char_cnt), 64'(0));
        @(negedge clk);
        check("lat.e1_cnt", 64'(char_cnt), 64'(1));
        check("lat.e1_slot0", 64'(char_buf[6:0]), 64'(7'h61));
        key_down = '0;
        repeat (2) @(negedge clk);

        // Directed table from reset
        do_reset();
        foreach (vecs[i]) begin
            press(vecs[i].code, 1);
            check($sformatf("tbl%0d.cnt", i),     64'(char_cnt),    64'(vecs[i].cnt));
            check($sformatf("tbl%0d.cap", i),     64'(capital),     64'(vecs[i].cap));
            check($sformatf("tbl%0d.buf", i),     64'(char_buf),    64'(vecs[i].buf_v));
            check($sformatf("tbl%0d.ovf", i),     64'(mon_ovf),     64'(vecs[i].ovf));
            check($sformatf("tbl%0d.commits", i), 64'(mon_commits), 64'(vecs[i].commits));
            check($sformatf("tbl%0d.cdata", i),   64'(mon_cdata),   64'(vecs[i].cdata));
            check($sformatf("tbl%0d.ccnt", i),    64'(mon_ccnt),    64'(vecs[i].ccnt));
        end

        // Overflow on a full buffer pulses for exactly one cycle
        do_reset();
        for (int c = 0; c < 4; c++) press(5'(c), 1);
        key_on(5'd4);
        @(negedge clk);
        check("ovf.e0", 64'(overflow), 64'(0));
        @(negedge clk);
        check("ovf.e1", 64'(overflow), 64'(1));
        check("ovf.buf", 64'(char_buf), 64'(pk(7'h61, 7'h62, 7'h63, 7'h64)));
        @(negedge clk);
        check("ovf.e2", 64'(overflow), 64'(0));
        key_down = '0;
        repeat (2) @(negedge clk);
        model_key(4);
        compare_all("ovf");

        // Commit of "ab": one-cycle pulse, buffer cleared on the same edge
        do_reset();
        press(5'd0, 1);
        press(5'd1, 2);
        key_on(5'd28);
        @(negedge clk);
        check("cmt.e0", 64'(commit_valid), 64'(0));
        @(negedge clk);
        check("cmt.e1", 64'(commit_valid), 64'(1));
        check("cmt.data", 64'(commit_data[13:0]), 64'({7'h62, 7'h61}));
        check("cmt.ccnt", 64'(commit_cnt), 64'(2));
        check("cmt.cleared", 64'({char_cnt, char_buf}), 64'(0));
        @(negedge clk);
        check("cmt.e2", 64'(commit_valid), 64'(0));
        key_down = '0;
        repeat (2) @(negedge clk);
        model_key(28);
        compare_all("cmt");

        // Reset during the enter action discards the line and the commit
        do_reset();
        press(5'd0, 1);
        press(5'd1, 1);
        key_on(5'd28);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rstcmt");
        key_down = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Long hold: repeats when compiled in, a single event otherwise
        do_reset();
        press(5'd0, 20);
`ifdef KEY_ENTRY_REPEAT_EN
        check("rep.cnt4", 64'(char_cnt), 64'(4));
        check("rep.buf", 64'(char_buf), 64'(pk(7'h61, 7'h61, 7'h61, 7'h61)));
`else
        check("hold.cnt1", 64'(char_cnt), 64'(1));
`endif
        compare_all("hold_a");
        press(5'd28, 20);
        compare_all("hold_enter");
        press(5'd27, 20);
        compare_all("hold_caps");

        // Reset mid-hold
        press(5'd1, 1);
        key_on(5'd0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rsthold");
        key_down = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Random presses against the model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            press(5'($urandom_range(31, 0)), $urandom_range(4, 1));
            repeat ($urandom_range(2, 0)) @(negedge clk);
            compare_all($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
